fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch sequencer for the ARM processor. Owns the PC and drives the address of the
//  combinational, word-indexed instruction_memory (read data valid in the same cycle).
//  Buffers fetched words in a small prefetch queue and hands {pc, instr} to decode over valid/ready.
//  Decode redirects it on taken branches or exceptions.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC after reset; bits [1:0] must be 0
//  DEPTH      4              prefetch queue entries (power of 2, >= 2)
//  MEM_WORDS  32             instruction_memory size in words; used only by FETCH_OOB_CHECK_EN
// PORTS
//  clk             in   1   system clock; all state updates on posedge
//  rst_n           in   1   asynchronous reset, active-low
//  fetch_en        in   1   1 = fetch allowed; 0 = hold PC, no new pushes (queue still drains)
//  imem_addr       out  32  byte address to instruction_memory.A (always equals pc)
//  imem_rdata      in   32  instruction_memory.RD, valid in the same cycle as imem_addr
//  inst_valid      out  1   queue head valid
//  inst_ready      in   1   decode accepts the head when inst_valid & inst_ready
//  inst_data       out  32  queue head instruction word
//  inst_pc         out  32  byte address of inst_data
//  redirect_valid  in   1   flush the queue and load redirect_pc
//  redirect_pc     in   32  new fetch address; bits [1:0] are forced to 00
//  fault           out  1   sticky out-of-range fetch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, queue empty, inst_valid=0,
//   inst_data=0, inst_pc=0, fault=0. Reset mid-operation discards all queued entries at once.
//  push = fetch_en & !redirect_valid & !fault & (count<DEPTH | pop)
//  pop  = inst_valid & inst_ready & !redirect_valid
//  On push:
//   - {pc, imem_rdata} is written at the tail on the clock edge.
//   - pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
//  Latency: the word fetched in cycle N is visible at the head in cycle N+1 at the earliest.
//  There is no combinational bypass from imem_rdata to inst_data.
//  Full with a pop in the same cycle: push is allowed; count is unchanged.
//  Empty: inst_valid=0. inst_data and inst_pc hold their last values; decode must not sample them.
//  count is held in a $clog2(DEPTH)+1-bit counter. Read and write pointers wrap modulo DEPTH.
//  Redirect (priority over push and pop in the same cycle):
//   - queue flushed (count=0), pc <= {redirect_pc[31:2],2'b00}, fault cleared.
//   - Any handshake presented that cycle is discarded.
//   - inst_valid=0 in cycle N+1.
//   - The first redirected fetch occurs in N+1; its instruction is valid at the head in N+2.
//  fetch_en=0: pc frozen, no push; pops continue until empty.
//  inst_valid, once asserted, stays high with a stable head until popped or redirected.
//  Internal state: none beyond pc/queue/count/fault (no FSM beyond RUN vs FAULT in CONFIGURATION).
// CONFIGURATION
//  FETCH_OOB_CHECK_EN defined:
//   - If pc[31:2] >= MEM_WORDS when a push would occur, the push is suppressed, pc holds,
//     and fault <= 1 (FAULT state).
//   - FAULT blocks all pushes while the queue still drains.
//   - FAULT exits only on redirect or reset.
//  FETCH_OOB_CHECK_EN undefined:
//   - No range check; fault is tied to 0.
//   - Out-of-range addresses pass through to the memory unchanged.
// TESTING
//  1 Reset:
//     rst_n=0 mid-stream, then release with fetch_en=1, inst_ready=1, memory word i = 32'hE000_0000+i
//     -> inst_valid rises one cycle after release; inst_pc = 0,4,8,... with matching data; one instr per cycle.
//  2 Backpressure:
//     inst_ready=0 for 10 cycles (DEPTH=4)
//     -> queue holds pc 0..12, imem_addr stalls at 16, head stable at pc=0.
//     Then inst_ready=1 -> 0,4,8,12,16 in order with no gaps and no duplicates.
//  3 Redirect:
//     redirect_valid=1, redirect_pc=32'h0000_0043 while queue full and inst_ready=1
//     -> no pop that cycle; inst_valid=0 next cycle; next head inst_pc=32'h40, then 32'h44.
//  4 Full with simultaneous pop:
//     count=DEPTH, inst_ready=1 every cycle
//     -> count stays DEPTH and exactly one push per cycle. Check with a scoreboard of pc order.
//  5 Out of range (OOB_CHECK on, MEM_WORDS=32):
//     run sequentially from 0 -> last push pc=32'h7C, fault=1, queue drains to empty, inst_valid=0.
//     redirect_pc=0 -> fault=0 and fetching resumes at 0.
//     With the macro off: fetch continues to pc=32'h80, fault stays 0.
//  6 PC wrap:
//     redirect_pc=32'hFFFF_FFF8, OOB check off -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch sequencer. Owns the PC, drives the word-indexed
// instruction memory (combinational read, data valid in the same cycle),
// buffers fetched {pc, instr} pairs in a small prefetch queue and hands the
// queue head to decode over a valid/ready handshake. Decode can redirect the
// fetch stream (taken branch / exception), which flushes the queue.
//
// Optional feature macro: FETCH_OOB_CHECK_EN
//   defined   : fetches with pc[31:2] >= MEM_WORDS are suppressed, the PC
//               holds and a sticky fault is raised (RUN -> FAULT). Only a
//               redirect or reset leaves FAULT; the queue still drains.
//   undefined : no range check, fault is tied low.
//
// Parameters
//   RESET_PC   PC after reset (bits [1:0] must be 0)
//   DEPTH      prefetch queue entries (power of 2, >= 2)
//   MEM_WORDS  instruction memory size in words (range check only)
//
// Ports
//   clk             in   system clock, all state updates on posedge
//   rst_n           in   asynchronous active-low reset
//   fetch_en        in   1 = fetch allowed, 0 = hold PC (queue still drains)
//   imem_addr       out  byte address to instruction memory (== pc)
//   imem_rdata      in   instruction word at imem_addr, same cycle
//   inst_valid      out  queue head valid
//   inst_ready      in   decode accepts head when inst_valid & inst_ready
//   inst_data       out  queue head instruction word
//   inst_pc         out  byte address of inst_data
//   redirect_valid  in   flush queue and load redirect_pc
//   redirect_pc     in   new fetch address, bits [1:0] forced to 00
//   fault           out  sticky out-of-range fetch flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Elaboration-time parameter sanity checks.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_unit: RESET_PC must be word aligned");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_unit: DEPTH must be a power of 2 and >= 2");
    end
    if (MEM_WORDS < 1) begin : g_bad_mem_words
        $error("fetch_unit: MEM_WORDS must be >= 1");
    end

    logic [31:0]   pc;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   hold_pc;
    logic [31:0]   hold_data;

    logic          has_room;
    logic          fetch_try;
    logic          push;
    logic          pop;
    logic          fault_blk;
    logic          oob;

    assign imem_addr  = pc;
    assign inst_valid = (count != '0);
    assign has_room   = (count < FULL_COUNT);

    // A fetch would happen this cycle if nothing but the range check or a
    // fault state stood in the way.
    assign fetch_try = fetch_en & ~redirect_valid & (has_room | pop);
    assign pop       = inst_valid & inst_ready & ~redirect_valid;
    assign push      = fetch_try & ~fault_blk & ~oob;

`ifdef FETCH_OOB_CHECK_EN
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    assign oob = ({2'b00, pc[31:2]} >= 32'(MEM_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fault_blk = 1'b0;
        case (state)
            RUN: begin
                if (fetch_try && oob) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                fault_blk = 1'b1;
                if (redirect_valid) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign fault = (state == FAULT);
`else
    assign oob       = 1'b0;
    assign fault_blk = 1'b0;
    assign fault     = 1'b0;
`endif

    // PC, pointers and occupancy. Redirect wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= pc;
            q_data[wr_ptr] <= imem_rdata;
        end
    end

    // Shadow of the last visible head so the outputs hold their last value
    // (zero after reset) while the queue is empty instead of exposing stale
    // storage slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc   <= '0;
            hold_data <= '0;
        end else if (inst_valid) begin
            hold_pc   <= q_pc[rd_ptr];
            hold_data <= q_data[rd_ptr];
        end
    end

    assign inst_pc   = inst_valid ? q_pc[rd_ptr]   : hold_pc;
    assign inst_data = inst_valid ? q_data[rd_ptr] : hold_data;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit (default parameters). A behavioural
// instruction memory returns 32'hE000_0000 + word index. A per-cycle vector
// table covers reset, steady streaming, backpressure and full-with-pop; short
// hand sequences cover redirect, out-of-range fetch and PC wrap. Every
// accepted handshake is checked against a queue of expected PCs.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (4),
        .MEM_WORDS (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hE000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_rdata = word_of(imem_addr);

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc   = '0;
    logic [31:0] sb_e;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait for the falling edge, then check handshakes against the
    // scoreboard and that a stalled head stays put.
    task automatic sample();
        @(negedge clk);
        if (rst_n) begin
            if (prev_hold) begin
                chk("stall_valid", {31'b0, inst_valid}, 32'd1);
                chk("stall_pc", inst_pc, prev_pc);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got handshake pc %h, required none", inst_pc);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_pc", inst_pc, sb_e);
                    chk("sb_data", inst_data, word_of(sb_e));
                end
            end
        end
        prev_hold = rst_n && inst_valid && !inst_ready && !redirect_valid;
        prev_pc   = inst_pc;
    endtask

    // Redirect with inst_ready high, expect n sequential handshakes from the
    // aligned target, then stall and confirm the scoreboard drained.
    task automatic redirect_run(input logic [31:0] tgt, input int unsigned n);
        logic [31:0] base;
        base = {tgt[31:2], 2'b00};
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        inst_ready     = 1'b1;
        fetch_en       = 1'b1;
        sample();
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        chk("rd_valid_n1", {31'b0, inst_valid}, 32'd0);
        chk("rd_addr_n1", imem_addr, base);
        chk("rd_fault_n1", {31'b0, fault}, 32'd0);
        repeat (n) begin
            next_cycle();
            sample();
        end
        next_cycle();
        inst_ready = 1'b0;
        sample();
        chk("rd_sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rv;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        zero;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] eaddr, input logic zero);
        vec_t v;
        v.rst_n = r;   v.rdy = rdy; v.rv = rv;
        v.ev    = ev;  v.epc = epc; v.eaddr = eaddr; v.zero = zero;
        return v;
    endfunction

    initial begin
        // rst rdy rv | valid pc addr zero
        tbl.push_back(mk(0, 1, 0, 0, 32'd0,  32'd0,  1)); // reset mid-stream
        tbl.push_back(mk(1, 1, 0, 0, 32'd0,  32'd0,  1)); // released
        tbl.push_back(mk(1, 1, 0, 1, 32'd0,  32'd4,  0)); // valid one cycle later
        tbl.push_back(mk(1, 1, 0, 1, 32'd4,  32'd8,  0));
        tbl.push_back(mk(1, 1, 0, 1, 32'd8,  32'd12, 0));
        tbl.push_back(mk(1, 1, 1, 1, 32'd12, 32'd16, 0)); // redirect to 0
        tbl.push_back(mk(1, 0, 0, 0, 32'd0,  32'd0,  0)); // 10 stall cycles
        tbl.push_back(mk(1, 0, 0, 1, 32'd0,  32'd4,  0));
        tbl.push_back(mk(1, 0, 0, 1, 32'd0,  32'd8,  0));
        tbl.push_back(mk(1, 0, 0, 1, 32'd0,  32'd12, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 0, 0, 1, 32'd0, 32'd16, 0));
        tbl.push_back(mk(1, 1, 0, 1, 32'd0,  32'd16, 0)); // full + pop
        tbl.push_back(mk(1, 1, 0, 1, 32'd4,  32'd20, 0));
        tbl.push_back(mk(1, 1, 0, 1, 32'd8,  32'd24, 0));
        tbl.push_back(mk(1, 1, 0, 1, 32'd12, 32'd28, 0));
        tbl.push_back(mk(1, 1, 0, 1, 32'd16, 32'd32, 0));
        tbl.push_back(mk(1, 1, 0, 1, 32'd20, 32'd36, 0));
        tbl.push_back(mk(1, 0, 0, 1, 32'd24, 32'd40, 0)); // refills to full

        foreach (tbl[i]) ;
        exp_q = '{32'd0, 32'd4, 32'd8, 32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};

        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            next_cycle();
            sample();
        end

        for (int i = 0; i < tbl.size(); i++) begin
            next_cycle();
            rst_n          = tbl[i].rst_n;
            inst_ready     = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = '0;
            sample();
            chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
            chk($sformatf("v%0d_fault", i), {31'b0, fault}, 32'd0);
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].epc);
                chk($sformatf("v%0d_data", i), inst_data, word_of(tbl[i].epc));
            end
            if (tbl[i].zero) begin
                chk($sformatf("v%0d_rst_pc", i), inst_pc, 32'd0);
                chk($sformatf("v%0d_rst_data", i), inst_data, 32'd0);
            end
        end
        redirect_valid = 1'b0;
        chk("table_sb_drained", 32'(exp_q.size()), 32'd0);

        // Redirect while full with ready high: unaligned target aligns to 0x40.
        redirect_run(32'h0000_0043, 2);

`ifdef FETCH_OOB_CHECK_EN
        // Last in-range word is 0x7C; the fetch at 0x80 faults.
        redirect_run(32'h0000_0074, 3);
        chk("oob_fault", {31'b0, fault}, 32'd1);
        chk("oob_valid", {31'b0, inst_valid}, 32'd0);
        chk("oob_addr", imem_addr, 32'h0000_0080);
        repeat (3) begin
            next_cycle();
            sample();
        end
        chk("oob_fault_sticky", {31'b0, fault}, 32'd1);
        chk("oob_addr_held", imem_addr, 32'h0000_0080);
        redirect_run(32'h0000_0000, 2);
        chk("oob_fault_cleared", {31'b0, fault}, 32'd0);
`else
        // No range check: fetch runs past the memory size.
        redirect_run(32'h0000_0074, 5);
        chk("nooob_fault", {31'b0, fault}, 32'd0);
        // PC wraps modulo 2^32.
        redirect_run(32'hFFFF_FFF8, 3);
        chk("wrap_fault", {31'b0, fault}, 32'd0);
`endif

        // fetch_en low: PC frozen, queue drains.
        next_cycle();
        fetch_en = 1'b0;
        sample();
        sb_e = imem_addr;
        repeat (3) begin
            next_cycle();
            sample();
        end
        chk("fe0_addr_frozen", imem_addr, sb_e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
